// File: rtl/int_mul_pkg.sv
// Shared types for the pipelined integer multiplier: operation modes and
// the per-mode operand-signedness / result-half decode.
package int_mul_pkg;

  typedef enum logic [1:0] {
    MUL_LO = 2'b00,
    MULH   = 2'b01,
    MULHU  = 2'b10,
    MULHSU = 2'b11
  } mul_mode_e;

  typedef struct packed {
    logic a_signed;
    logic b_signed;
    logic high_sel;
  } mode_ctl_t;

  function automatic mode_ctl_t mode_ctl(input mul_mode_e mode);
    mode_ctl_t ctl;
    case (mode)
      MUL_LO:  ctl = {1'b0, 1'b0, 1'b0};
      MULH:    ctl = {1'b1, 1'b1, 1'b1};
      MULHU:   ctl = {1'b0, 1'b0, 1'b1};
      MULHSU:  ctl = {1'b1, 1'b0, 1'b1};
      default: ctl = {1'b0, 1'b0, 1'b0};
    endcase
    return ctl;
  endfunction

endpackage

// File: rtl/int_mul_pipe_stage.sv
// One multiplier pipeline stage: folds the next C-bit chunk of the b magnitude
// into the accumulator on load, and tracks its own valid/advance state.
module int_mul_pipe_stage
  import int_mul_pkg::*;
#(
  parameter int W = 32,
  parameter int C = 8,
  parameter int K = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_i,
  input  logic             dn_rdy_i,
  input  mul_mode_e        mode_i,
  input  logic             neg_i,
  input  logic [W-1:0]     ma_i,
  input  logic [W-1:0]     mb_i,
  input  logic [2*W-1:0]   acc_i,
  output logic             val_o,
  output logic             go_o,
  output mul_mode_e        mode_o,
  output logic             neg_o,
  output logic [W-1:0]     ma_o,
  output logic [W-1:0]     mb_o,
  output logic [2*W-1:0]   acc_o
);

  logic           val_q, val_d;
  mul_mode_e      mode_q, mode_d;
  logic           neg_q, neg_d;
  logic [W-1:0]   ma_q, ma_d;
  logic [W-1:0]   mb_q, mb_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [2*W-1:0] pp_s;
  logic           go_s;

  // Chunk partial product, aligned to this stage's bit position
  always_comb begin
    pp_s = ({{W{1'b0}}, ma_i} * {{(2*W-C){1'b0}}, mb_i[C-1:0]}) << ((K-1)*C);
  end

  // Stage advances when it holds data and downstream can take it
  always_comb begin
    go_s = val_q & dn_rdy_i;
  end

  // Next-state: load from upstream, drain on advance, otherwise hold
  always_comb begin
    val_d  = val_q;
    mode_d = mode_q;
    neg_d  = neg_q;
    ma_d   = ma_q;
    mb_d   = mb_q;
    acc_d  = acc_q;
    if (ld_i) begin
      val_d  = 1'b1;
      mode_d = mode_i;
      neg_d  = neg_i;
      ma_d   = ma_i;
      mb_d   = mb_i >> C;
      acc_d  = acc_i + pp_s;
    end else if (go_s) begin
      val_d  = 1'b0;
    end else begin
      val_d  = val_q;
    end
  end

  // Stage register set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q  <= 1'b0;
      mode_q <= MUL_LO;
      neg_q  <= 1'b0;
      ma_q   <= {W{1'b0}};
      mb_q   <= {W{1'b0}};
      acc_q  <= {(2*W){1'b0}};
    end else begin
      val_q  <= val_d;
      mode_q <= mode_d;
      neg_q  <= neg_d;
      ma_q   <= ma_d;
      mb_q   <= mb_d;
      acc_q  <= acc_d;
    end
  end

  assign val_o  = val_q;
  assign go_o   = go_s;
  assign mode_o = mode_q;
  assign neg_o  = neg_q;
  assign ma_o   = ma_q;
  assign mb_o   = mb_q;
  assign acc_o  = acc_q;

endmodule

// File: rtl/int_mul_pipe.sv
// Fully pipelined W x W multiplier with four RISC-V style modes. Operands are
// turned into magnitudes at entry; the sign is reapplied on the final product.
module int_mul_pipe
  import int_mul_pkg::*;
#(
  parameter int W       = 32,
  parameter int NSTAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_en,
  output logic             req_rdy,
  input  logic [2*W+1:0]   req_msg,
  output logic             resp_en,
  input  logic             resp_rdy,
  output logic [W-1:0]     resp_msg
);

  localparam int C = W / NSTAGES;
  localparam logic [W-1:0]   ONE_W  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [2*W-1:0] ONE_2W = {{(2*W-1){1'b0}}, 1'b1};

  mul_mode_e      in_mode_s;
  mode_ctl_t      in_ctl_s;
  logic [W-1:0]   in_a_s, in_b_s, in_ma_s, in_mb_s;
  logic           a_neg_s, b_neg_s, in_neg_s;

  logic [NSTAGES:1] val_s, go_s, neg_s;
  logic [NSTAGES:0] rdy_s;
  mul_mode_e        mode_s [1:NSTAGES];
  logic [W-1:0]     ma_s   [1:NSTAGES];
  logic [W-1:0]     mb_s   [1:NSTAGES];
  logic [2*W-1:0]   acc_s  [1:NSTAGES];

  mode_ctl_t      out_ctl_s;
  logic [2*W-1:0] prod_s;
  logic           unused_ok_s;

  // Entry: unpack request and replace negative signed operands by magnitudes
  always_comb begin
    in_mode_s = mul_mode_e'(req_msg[2*W+1:2*W]);
    in_ctl_s  = mode_ctl(in_mode_s);
    in_a_s    = req_msg[2*W-1:W];
    in_b_s    = req_msg[W-1:0];
    a_neg_s   = in_ctl_s.a_signed & in_a_s[W-1];
    b_neg_s   = in_ctl_s.b_signed & in_b_s[W-1];
    in_neg_s  = a_neg_s ^ b_neg_s;
    if (a_neg_s) begin
      in_ma_s = ~in_a_s + ONE_W;
    end else begin
      in_ma_s = in_a_s;
    end
    if (b_neg_s) begin
      in_mb_s = ~in_b_s + ONE_W;
    end else begin
      in_mb_s = in_b_s;
    end
  end

  // Ready chain: rdy_s[k] says stage k may advance into k+1 (or out)
  always_comb begin
    rdy_s          = {(NSTAGES+1){1'b0}};
    rdy_s[NSTAGES] = resp_rdy;
    for (int k = NSTAGES; k >= 1; k--) begin
      rdy_s[k-1] = ~val_s[k] | rdy_s[k];
    end
  end

  for (genvar k = 1; k <= NSTAGES; k++) begin : g_stage
    logic           in_ld_s;
    mul_mode_e      in_mode_k_s;
    logic           in_neg_k_s;
    logic [W-1:0]   in_ma_k_s, in_mb_k_s;
    logic [2*W-1:0] in_acc_k_s;

    if (k == 1) begin : g_first
      assign in_ld_s     = req_en;
      assign in_mode_k_s = in_mode_s;
      assign in_neg_k_s  = in_neg_s;
      assign in_ma_k_s   = in_ma_s;
      assign in_mb_k_s   = in_mb_s;
      assign in_acc_k_s  = {(2*W){1'b0}};
    end else begin : g_next
      assign in_ld_s     = go_s[k-1];
      assign in_mode_k_s = mode_s[k-1];
      assign in_neg_k_s  = neg_s[k-1];
      assign in_ma_k_s   = ma_s[k-1];
      assign in_mb_k_s   = mb_s[k-1];
      assign in_acc_k_s  = acc_s[k-1];
    end

    int_mul_pipe_stage #(
      .W (W),
      .C (C),
      .K (k)
    ) u_stage (
      .clk      (clk),
      .rst_n    (reset),
      .ld_i     (in_ld_s),
      .dn_rdy_i (rdy_s[k]),
      .mode_i   (in_mode_k_s),
      .neg_i    (in_neg_k_s),
      .ma_i     (in_ma_k_s),
      .mb_i     (in_mb_k_s),
      .acc_i    (in_acc_k_s),
      .val_o    (val_s[k]),
      .go_o     (go_s[k]),
      .mode_o   (mode_s[k]),
      .neg_o    (neg_s[k]),
      .ma_o     (ma_s[k]),
      .mb_o     (mb_s[k]),
      .acc_o    (acc_s[k])
    );
  end

  // Output: restore the sign on the full product, then pick the requested half
  always_comb begin
    out_ctl_s = mode_ctl(mode_s[NSTAGES]);
    if (neg_s[NSTAGES]) begin
      prod_s = ~acc_s[NSTAGES] + ONE_2W;
    end else begin
      prod_s = acc_s[NSTAGES];
    end
    if (out_ctl_s.high_sel) begin
      resp_msg = prod_s[2*W-1:W];
    end else begin
      resp_msg = prod_s[W-1:0];
    end
  end

  assign req_rdy = rdy_s[0];
  assign resp_en = go_s[NSTAGES];

  // The last stage's operand copies and some decode bits have no consumer
  assign unused_ok_s = ^{in_ctl_s.high_sel, out_ctl_s.a_signed, out_ctl_s.b_signed,
                         ma_s[NSTAGES], mb_s[NSTAGES]};

endmodule

// File: tb/tb_int_mul_pipe.sv
// Directed and randomized bench for int_mul_pipe (W=32, NSTAGES=4) checked
// against a sign-extend-and-multiply reference model with an in-order queue.
module tb_int_mul_pipe;

  logic        clk;
  logic        reset;
  logic        req_en;
  logic        req_rdy;
  logic [65:0] req_msg;
  logic        resp_en;
  logic        resp_rdy;
  logic [31:0] resp_msg;

  typedef struct {
    logic [31:0] data;
    int          t;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors;
  int          miscompares;
  int          cyc;
  int          n_resp;
  bit          lat_chk;
  logic [31:0] cur_exp;

  int_mul_pipe #(.W(32), .NSTAGES(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_en   (req_en),
    .req_rdy  (req_rdy),
    .req_msg  (req_msg),
    .resp_en  (resp_en),
    .resp_rdy (resp_rdy),
    .resp_msg (resp_msg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] ref_mul(input logic [1:0] m, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [65:0] ea, eb, pr;
    bit as, bs;
    as = (m == 2'b01) || (m == 2'b11);
    bs = (m == 2'b01);
    ea = as ? {{34{a[31]}}, a} : {34'd0, a};
    eb = bs ? {{34{b[31]}}, b} : {34'd0, b};
    pr = ea * eb;
    return (m == 2'b00) ? pr[31:0] : pr[63:32];
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  // One clock cycle: decide the transfer, score any response, wait to next negedge
  task automatic step(input bit want, output bit accepted);
    exp_t e;
    #1;
    req_en   = want && req_rdy;
    accepted = req_en;
    if (resp_en) begin
      if (exp_q.size() == 0) begin
        check("spurious_resp", 32'(resp_en), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("resp_msg", resp_msg, e.data);
        if (lat_chk) check("latency", 32'(cyc - e.t), 32'd4);
        n_resp++;
      end
    end
    if (accepted) exp_q.push_back('{data: cur_exp, t: cyc});
    cyc++;
    @(negedge clk);
  endtask

  task automatic send(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                      input bit use_exp, input logic [31:0] ev);
    bit acc;
    int n;
    req_msg = {m, a, b};
    cur_exp = use_exp ? ev : ref_mul(m, a, b);
    acc = 1'b0;
    n = 0;
    while (!acc && n < 64) begin
      step(1'b1, acc);
      n++;
    end
    check("req_accept", 32'(acc), 32'd1);
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) step(1'b0, acc);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      idle(1);
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    idle(2);
  endtask

  initial begin
    bit acc;
    int r0;
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    n_resp      = 0;
    lat_chk     = 1'b1;
    cur_exp     = 32'd0;
    reset       = 1'b0;
    req_en      = 1'b0;
    req_msg     = 66'd0;
    resp_rdy    = 1'b1;

    // Reset state, during and after reset
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_req_rdy", 32'(req_rdy), 32'd1);
    check("rst_resp_en", 32'(resp_en), 32'd0);
    check("rst_resp_msg", resp_msg, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("post_rst_req_rdy", 32'(req_rdy), 32'd1);
    check("post_rst_resp_en", 32'(resp_en), 32'd0);
    @(negedge clk);

    // Single MUL with exact latency
    r0 = n_resp;
    send(2'b00, 32'h0000_0007, 32'h0000_0006, 1'b1, 32'h0000_002A);
    idle(6);
    check("single_count", 32'(n_resp - r0), 32'd1);

    // All four modes on a=-1, b=2, then signed-minimum corners
    send(2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 32'hFFFF_FFFE);
    send(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 32'hFFFF_FFFF);
    send(2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 32'h0000_0001);
    send(2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 32'hFFFF_FFFF);
    send(2'b01, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000);
    send(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0000);
    drain();

    // Eight back-to-back: latency 4 on each implies gap-free, in-order output
    r0 = n_resp;
    for (int i = 0; i < 8; i++) begin
      send(2'($urandom_range(0, 3)), $urandom, $urandom, 1'b0, 32'd0);
    end
    drain();
    check("b2b_count", 32'(n_resp - r0), 32'd8);

    // Back-pressure: fill, hold, release
    lat_chk  = 1'b0;
    r0       = n_resp;
    resp_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(2'(i), 32'h1234_5678 + 32'(i), 32'hFEDC_BA98 - 32'(i), 1'b0, 32'd0);
    end
    req_en = 1'b0;
    #1;
    check("stall_req_rdy", 32'(req_rdy), 32'd0);
    repeat (3) begin
      #1;
      check("stall_msg_hold", resp_msg, exp_q[0].data);
      check("stall_resp_en", 32'(resp_en), 32'd0);
      step(1'b0, acc);
    end
    resp_rdy = 1'b1;
    req_msg  = {2'b01, 32'h8000_0001, 32'h7FFF_FFFF};
    cur_exp  = ref_mul(2'b01, 32'h8000_0001, 32'h7FFF_FFFF);
    #1;
    check("release_req_rdy", 32'(req_rdy), 32'd1);
    check("release_resp_en", 32'(resp_en), 32'd1);
    step(1'b1, acc);
    check("release_accept", 32'(acc), 32'd1);
    send(2'b11, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0, 32'd0);
    drain();
    check("stall_count", 32'(n_resp - r0), 32'd6);
    lat_chk = 1'b1;

    // Asynchronous reset with three requests in flight
    for (int i = 0; i < 3; i++) begin
      send(2'b10, 32'(i + 11), 32'(i + 3), 1'b0, 32'd0);
    end
    req_en = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_resp_en", 32'(resp_en), 32'd0);
    check("async_rst_req_rdy", 32'(req_rdy), 32'd1);
    check("async_rst_resp_msg", resp_msg, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    cyc++;
    exp_q.delete();
    r0 = n_resp;
    idle(6);
    check("rst_discard", 32'(n_resp - r0), 32'd0);
    send(2'b00, 32'h0000_0003, 32'h0000_0005, 1'b1, 32'h0000_000F);
    drain();
    check("post_rst_count", 32'(n_resp - r0), 32'd1);

    // Randomized traffic with random back-pressure and gaps
    lat_chk = 1'b0;
    for (int i = 0; i < 200; i++) begin
      logic [1:0]  m;
      logic [31:0] a, b;
      m        = 2'($urandom_range(0, 3));
      a        = pick_operand();
      b        = pick_operand();
      resp_rdy = ($urandom_range(0, 3) != 0);
      req_msg  = {m, a, b};
      cur_exp  = ref_mul(m, a, b);
      step($urandom_range(0, 2) != 0, acc);
    end
    resp_rdy = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
